ram_sweep: RTL

//  Parametrised single-port data RAM: byte-lane writes, registered reads and a

---
 rtl/ram_sweep.sv | 109 ++++++++++
 1 files changed

// File: rtl/ram_sweep.sv
// ram_sweep: byte-lane single-port data RAM with registered reads and a clear sweep.
// Build option RAM_BYPASS_EN selects write-first merge on same-address Store+Load.
module ram_sweep #(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 10,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              Clear,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] Din,
   input  logic [BE_W-1:0]   ByteEn,
   input  logic              Store,
   input  logic              Load,
   output logic [DATA_W-1:0] Data,
   output logic              DValid,
   output logic              Busy,
   output logic              Done
);

   localparam int              DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {S_SWEEP, S_IDLE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W:0]   r_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_data;
   logic              r_dvalid;
   logic              w_busy;
   logic              w_done;
   logic              w_wr;
   logic              w_rd;
   logic [DATA_W-1:0] w_rdata;

   always_ff @(posedge clk) begin
      if (Clear) r_state <= S_SWEEP;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      w_wr   = 1'b0;
      w_rd   = 1'b0;
      unique case (r_state)
         S_SWEEP: begin
            w_busy = 1'b1;
            if (r_cnt == LAST) begin
               w_done = !Clear;
               w_next = S_IDLE;
            end
         end
         S_IDLE: begin
            w_wr = Store && !Clear;
            w_rd = Load && !Clear;
         end
         default: ;
      endcase
   end

   // Counter is one bit wider than Addr so it never wraps mid-sweep.
   always_ff @(posedge clk) begin
      if (Clear)                   r_cnt <= '0;
      else if (r_state == S_SWEEP) r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (r_state == S_SWEEP) begin
         r_mem[r_cnt[ADDR_W-1:0]] <= '0;
      end else if (w_wr) begin
         for (int k = 0; k < BE_W; k++) begin
            if (ByteEn[k]) r_mem[Addr][8*k +: 8] <= Din[8*k +: 8];
         end
      end
   end

`ifdef RAM_BYPASS_EN
   always_comb begin
      w_rdata = r_mem[Addr];
      if (w_wr) begin
         for (int k = 0; k < BE_W; k++) begin
            if (ByteEn[k]) w_rdata[8*k +: 8] = Din[8*k +: 8];
         end
      end
   end
`else
   assign w_rdata = r_mem[Addr];
`endif

   always_ff @(posedge clk) begin
      if (Clear) begin
         r_data   <= '0;
         r_dvalid <= 1'b0;
      end else begin
         r_dvalid <= w_rd;
         if (w_rd) r_data <= w_rdata;
      end
   end

   assign Data   = r_data;
   assign DValid = r_dvalid;
   assign Busy   = w_busy;
   assign Done   = w_done;

endmodule
